pipeline_ctrl: RTL

Central stall/flush sequencer for the 5-stage pipeline. It owns the enables and bubble controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB. It runs the data-memory request/acknowledge handshake for the instruction in MEM, detects load-use hazards, and applies branch flushes. It also counts stall cycles and reports memory timeouts.

---
 rtl/pipeline_ctrl_if.sv | 46 ++++
 rtl/pipeline_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: pipeline-control bundle between the stall/flush sequencer
// and the pipeline datapath / data memory.
//   master : the sequencer. It reads the hazard, branch and memory-op inputs
//            and drives the memory request, the stage enables, the bubble
//            controls, the timeout flag and the stall counter.
//   slave  : the datapath/memory side, with the opposite directions.
// CNT_W sets the width of the stall counter output.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic [4:0]       id_rs_i;
    logic [4:0]       id_rt_i;
    logic             ex_memread_i;
    logic [4:0]       ex_rt_i;
    logic             branch_taken_i;
    logic             mem_read_i;
    logic             mem_write_i;
    logic             mem_ack_i;
    logic             mem_req_o;
    logic             mem_we_o;
    logic             pc_write_o;
    logic             ifid_write_o;
    logic             ifid_flush_o;
    logic             idex_write_o;
    logic             idex_bubble_o;
    logic             exmem_write_o;
    logic             memwb_bubble_o;
    logic             mem_err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport master (
        input  id_rs_i, id_rt_i, ex_memread_i, ex_rt_i, branch_taken_i,
               mem_read_i, mem_write_i, mem_ack_i,
        output mem_req_o, mem_we_o, pc_write_o, ifid_write_o, ifid_flush_o,
               idex_write_o, idex_bubble_o, exmem_write_o, memwb_bubble_o,
               mem_err_o, stall_cnt_o
    );

    modport slave (
        output id_rs_i, id_rt_i, ex_memread_i, ex_rt_i, branch_taken_i,
               mem_read_i, mem_write_i, mem_ack_i,
        input  mem_req_o, mem_we_o, pc_write_o, ifid_write_o, ifid_flush_o,
               idex_write_o, idex_bubble_o, exmem_write_o, memwb_bubble_o,
               mem_err_o, stall_cnt_o
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline.
// It owns the PC, IF_ID, ID_EX, EX_MEM and MEM_WB enables and bubble controls.
// It also runs the data-memory request/ack handshake for the instruction in MEM
// (IDLE -> ACCESS -> DONE), detects load-use hazards, and applies branch
// flushes. Stalled cycles are counted in a saturating counter. A memory access
// that is never acknowledged is forced complete after MEM_TIMEOUT cycles and
// sets a sticky error flag.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous active-low reset
//   bus   : pipeline_ctrl_if master modport (hazard/branch/memory inputs,
//           stage controls, mem_req/mem_we, mem_err, stall_cnt)
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    pipeline_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Value of the wait counter in the last ACCESS cycle before a forced
    // completion.
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      wait_cnt;
    logic             op_we;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;

    logic             mem_op;
    logic             timeout_hit;
    logic             mem_stall;
    logic             load_use;

    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_write;
    logic             memwb_bubble;

    assign mem_op      = bus.mem_read_i | bus.mem_write_i;
    assign timeout_hit = (wait_cnt == WAIT_LAST);
    assign load_use    = bus.ex_memread_i && (bus.ex_rt_i != 5'd0) &&
                         ((bus.ex_rt_i == bus.id_rs_i) || (bus.ex_rt_i == bus.id_rt_i));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The write qualifier is captured when the access starts. The MEM inputs
    // are held for the whole stall, so this is equivalent to following
    // mem_write_i, but mem_we_o then depends on registers only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            op_we <= 1'b0;
        end else if (state == IDLE && mem_op) begin
            op_we <= bus.mem_write_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wait_cnt <= '0;
        end else if (state == ACCESS) begin
            wait_cnt <= wait_cnt + 16'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_err <= 1'b0;
        end else if (state == ACCESS && !bus.mem_ack_i && timeout_hit) begin
            mem_err <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
        end else if (!pc_write && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = mem_op;
                if (mem_op) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_stall = 1'b1;
                if (bus.mem_ack_i || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage controls. The checks run from highest to lowest priority:
    // reset, memory stall, load-use, branch, normal.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        memwb_bubble = 1'b0;
        if (!rst_i) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_write   = 1'b0;
            idex_bubble  = 1'b1;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (load_use) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
        end else if (bus.branch_taken_i) begin
            ifid_flush   = 1'b1;
        end
    end

    assign bus.mem_req_o      = (state == ACCESS);
    assign bus.mem_we_o       = (state == ACCESS) && op_we;
    assign bus.pc_write_o     = pc_write;
    assign bus.ifid_write_o   = ifid_write;
    assign bus.ifid_flush_o   = ifid_flush;
    assign bus.idex_write_o   = idex_write;
    assign bus.idex_bubble_o  = idex_bubble;
    assign bus.exmem_write_o  = exmem_write;
    assign bus.memwb_bubble_o = memwb_bubble;
    assign bus.mem_err_o      = mem_err;
    assign bus.stall_cnt_o    = stall_cnt;

endmodule
